// File: rtl/mux_4to1_rr_sched.sv
// Round-robin scheduler for a shared 4:1 mux feeding a registered
// valid/ready output stream with a source-lane tag on each beat.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   req_valid/last     per-lane beat present / beat ends packet
//   req_ready          one-hot accept strobe toward the granted lane
//   sel, mux_dout      select driven to the mux, mux data coming back
//   out_valid/ready    output handshake
//   out_data/last/src  registered beat, last flag and source lane
//   busy               a grant is active or the output register is full
module mux_4to1_rr_sched #(
   parameter int DW        = 128,
   parameter int MAX_BURST = 16,
   parameter int CW        = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    req_valid,
   input  logic [3:0]    req_last,
   output logic [3:0]    req_ready,
   output logic [1:0]    sel,
   input  logic [DW-1:0] mux_dout,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic [1:0]    out_src,
   output logic          busy
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [1:0]    sel_q, sel_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ov_q, ov_d;
   logic [DW-1:0] od_q, od_d;
   logic          ol_q, ol_d;
   logic [1:0]    os_q, os_d;

   logic [1:0]    pick;
   logic [CW-1:0] cnt_inc;
   logic          grant_rdy;
   logic          accept;
   logic          burst_end;

   // Walk from the farthest offset down to the nearest so the lane
   // closest to ptr (in rotation order) wins.
   always_comb begin
      pick = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         if (req_valid[ptr_q + 2'(k)]) begin
            pick = ptr_q + 2'(k);
         end
      end
   end

   assign cnt_inc   = cnt_q + 1'b1;
   assign burst_end = (cnt_inc == CW'(MAX_BURST));
   assign grant_rdy = (state_q == GRANT) && (!ov_q || out_ready);
   assign accept    = grant_rdy && req_valid[sel_q];
   assign req_ready = grant_rdy ? (4'b0001 << sel_q) : 4'b0000;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      ov_d    = ov_q;
      od_d    = od_q;
      ol_d    = ol_q;
      os_d    = os_q;
      // Drained beat; an accept below refills in the same cycle.
      if (ov_q && out_ready) begin
         ov_d = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               sel_d   = pick;
               cnt_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (accept) begin
               od_d  = mux_dout;
               ol_d  = req_last[sel_q];
               os_d  = sel_q;
               ov_d  = 1'b1;
               cnt_d = cnt_inc;
               // Burst cap rotates without forcing out_last; the
               // packet continues at a later grant of this lane.
               if (req_last[sel_q] || burst_end) begin
                  ptr_d   = sel_q + 2'd1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         ov_q    <= 1'b0;
         od_q    <= '0;
         ol_q    <= 1'b0;
         os_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
         ol_q    <= ol_d;
         os_q    <= os_d;
      end
   end

   assign sel       = sel_q;
   assign out_valid = ov_q;
   assign out_data  = od_q;
   assign out_last  = ol_q;
   assign out_src   = os_q;
   assign busy      = (state_q == GRANT) || ov_q;

endmodule

// File: tb/tb_mux_4to1_rr_sched.sv
// Directed bench for mux_4to1_rr_sched (MAX_BURST=4).
// Lanes are modelled by per-lane beat counters feeding the mux.
module tb_mux_4to1_rr_sched;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid, req_last, req_ready;
   logic [1:0]   sel, out_src;
   logic [127:0] mux_dout, out_data;
   logic         out_valid, out_ready, out_last, busy;

   int total = 0;
   int bad   = 0;
   int cnt[4] = '{default: 0};

   mux_4to1_rr_sched #(.DW(128), .MAX_BURST(4), .CW(3)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_last(req_last),
      .req_ready(req_ready), .sel(sel), .mux_dout(mux_dout),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last),
      .out_src(out_src), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] mk(int lane, int n);
      return {8'(lane), 8'(n), 112'(64'hDEAD_BEEF_0BAD_F00D)};
   endfunction

   always_comb mux_dout = mk(int'(sel), cnt[sel]);

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (req_valid[i] && req_ready[i]) cnt[i] <= cnt[i] + 1;
      end
   end

   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic r, logic [3:0] v, logic [3:0] l, logic o);
      rst = r; req_valid = v; req_last = l; out_ready = o;
      #1;
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] rv, rl;
      logic       ordy;
      logic       ov, ol;
      logic [1:0] src, sel;
      logic [3:0] rdy;
      logic       busy;
      int         n;
   } vec_t;

   function automatic vec_t rw(logic r, logic [3:0] v, logic [3:0] l,
                               logic o, logic eov, logic eol,
                               logic [1:0] es, logic [1:0] esel,
                               logic [3:0] erdy, logic eb, int n);
      vec_t t;
      t.rst = r; t.rv = v; t.rl = l; t.ordy = o;
      t.ov = eov; t.ol = eol; t.src = es; t.sel = esel;
      t.rdy = erdy; t.busy = eb; t.n = n;
      return t;
   endfunction

   typedef struct { int src; int n; logic last; } bt_t;

   vec_t tbl[21];
   bt_t  q[$];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // T1 (rows 0-7), reset (8), T2 (9-20)
      tbl[0]  = rw(0, 4'h1, 4'h0, 1, 0, 0, 0, 0, 4'h0, 0, -1);
      tbl[1]  = rw(0, 4'h1, 4'h0, 1, 0, 0, 0, 0, 4'h1, 1, -1);
      tbl[2]  = rw(0, 4'h1, 4'h0, 1, 1, 0, 0, 0, 4'h1, 1, 0);
      tbl[3]  = rw(0, 4'h1, 4'h1, 1, 1, 0, 0, 0, 4'h1, 1, 1);
      tbl[4]  = rw(0, 4'h0, 4'h0, 1, 1, 1, 0, 0, 4'h0, 1, 2);
      tbl[5]  = rw(0, 4'h3, 4'h3, 1, 0, 0, 0, 0, 4'h0, 0, -1);
      tbl[6]  = rw(0, 4'h3, 4'h3, 1, 0, 0, 0, 1, 4'h2, 1, -1);
      tbl[7]  = rw(0, 4'h0, 4'h0, 1, 1, 1, 1, 1, 4'h0, 1, 0);
      tbl[8]  = rw(1, 4'h0, 4'h0, 1, 0, 0, 0, 1, 4'h0, 0, -1);
      tbl[9]  = rw(0, 4'hF, 4'hF, 1, 0, 0, 0, 0, 4'h0, 0, -1);
      tbl[10] = rw(0, 4'hF, 4'hF, 1, 0, 0, 0, 0, 4'h1, 1, -1);
      tbl[11] = rw(0, 4'hF, 4'hF, 1, 1, 1, 0, 0, 4'h0, 1, 3);
      tbl[12] = rw(0, 4'hF, 4'hF, 1, 0, 0, 0, 1, 4'h2, 1, -1);
      tbl[13] = rw(0, 4'hF, 4'hF, 1, 1, 1, 1, 1, 4'h0, 1, 1);
      tbl[14] = rw(0, 4'hF, 4'hF, 1, 0, 0, 0, 2, 4'h4, 1, -1);
      tbl[15] = rw(0, 4'hF, 4'hF, 1, 1, 1, 2, 2, 4'h0, 1, 0);
      tbl[16] = rw(0, 4'hF, 4'hF, 1, 0, 0, 0, 3, 4'h8, 1, -1);
      tbl[17] = rw(0, 4'hF, 4'hF, 1, 1, 1, 3, 3, 4'h0, 1, 0);
      tbl[18] = rw(0, 4'hF, 4'hF, 1, 0, 0, 0, 0, 4'h1, 1, -1);
      tbl[19] = rw(0, 4'h0, 4'h0, 1, 1, 1, 0, 0, 4'h0, 1, 4);
      tbl[20] = rw(0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 4'h0, 0, -1);

      drive(1, 4'h0, 4'h0, 1'b1);
      tick();
      tick();
      drive(0, 4'h0, 4'h0, 1'b1);
      chk("rst_ov", out_valid, 0);
      chk("rst_rdy", req_ready, 0);
      chk("rst_sel", sel, 0);
      chk("rst_data", out_data, 0);
      chk("rst_last", out_last, 0);
      chk("rst_src", out_src, 0);
      chk("rst_busy", busy, 0);

      for (int i = 0; i < 21; i++) begin
         drive(tbl[i].rst, tbl[i].rv, tbl[i].rl, tbl[i].ordy);
         chk($sformatf("v%0d_rdy", i), req_ready, tbl[i].rdy);
         chk($sformatf("v%0d_sel", i), sel, tbl[i].sel);
         chk($sformatf("v%0d_ov", i), out_valid, tbl[i].ov);
         chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
         if (tbl[i].ov) begin
            chk($sformatf("v%0d_last", i), out_last, tbl[i].ol);
            chk($sformatf("v%0d_src", i), out_src, tbl[i].src);
            chk($sformatf("v%0d_data", i), out_data,
                mk(int'(tbl[i].src), tbl[i].n));
         end
         tick();
      end

      // T3: lane2 stream, 5-cycle downstream stall mid-packet
      begin
         int en;
         en = 1;
         for (int i = 0; i < 30; i++) begin
            drive(0, (cnt[2] < 5) ? 4'h4 : 4'h0,
                  (cnt[2] == 4) ? 4'h4 : 4'h0, !(i >= 4 && i < 9));
            if (out_valid && !out_ready) begin
               chk("t3_stall_rdy", req_ready, 0);
               chk("t3_hold", out_data, mk(2, en));
            end
            if (out_valid && out_ready) begin
               chk("t3_data", out_data, mk(2, en));
               chk("t3_src", out_src, 2);
               chk("t3_last", out_last, en == 4);
               en++;
            end
            tick();
         end
         chk("t3_count", en, 5);
         chk("t3_acc", cnt[2], 5);
      end

      // T4: lane1 long packet capped at 4, lane2 2-beat packet
      begin
         int idx;
         bt_t b;
         for (int k = 2; k < 6; k++) q.push_back('{1, k, 1'b0});
         q.push_back('{2, 5, 1'b0});
         q.push_back('{2, 6, 1'b1});
         for (int k = 6; k < 12; k++) q.push_back('{1, k, 1'b0});
         idx = 0;
         for (int i = 0; i < 60; i++) begin
            drive(0, ((cnt[1] < 12) ? 4'h2 : 4'h0) |
                     ((cnt[2] < 7) ? 4'h4 : 4'h0),
                  (cnt[2] == 6) ? 4'h4 : 4'h0, 1'b1);
            if (out_valid) begin
               if (idx < 12) begin
                  b = q[idx];
                  chk($sformatf("t4_b%0d_src", idx), out_src, b.src);
                  chk($sformatf("t4_b%0d_data", idx), out_data,
                      mk(b.src, b.n));
                  chk($sformatf("t4_b%0d_last", idx), out_last, b.last);
               end else begin
                  chk("t4_extra", idx, 12);
               end
               idx++;
            end
            tick();
         end
         chk("t4_count", idx, 12);
         drive(0, 4'h0, 4'h0, 1'b1);
         chk("t4_lock_busy", busy, 1);
         chk("t4_lock_sel", sel, 1);
         chk("t4_lock_rdy", req_ready, 4'h2);
         chk("t4_lock_ov", out_valid, 0);
      end

      // T5: reset while out_valid=1 mid-packet, then lane3
      drive(0, 4'h2, 4'h0, 1'b0);
      chk("t5_rdy", req_ready, 4'h2);
      tick();
      drive(1, 4'h2, 4'h0, 1'b0);
      chk("t5_ov_pre", out_valid, 1);
      chk("t5_src_pre", out_src, 1);
      chk("t5_rdy_stall", req_ready, 0);
      tick();
      drive(0, 4'h0, 4'h0, 1'b1);
      chk("t5_ov_post", out_valid, 0);
      chk("t5_rdy_post", req_ready, 0);
      chk("t5_sel_post", sel, 0);
      chk("t5_busy_post", busy, 0);
      tick();
      drive(0, 4'h8, 4'h8, 1'b1);
      chk("t5_arb_rdy", req_ready, 0);
      tick();
      chk("t5_sel3", sel, 3);
      chk("t5_rdy3", req_ready, 4'h8);
      tick();

      // T6: ptr wrapped to 0; lanes 0 and 3 both valid
      drive(0, 4'h9, 4'h9, 1'b1);
      chk("t5_out_src", out_src, 3);
      chk("t5_out_data", out_data, mk(3, 1));
      chk("t5_out_last", out_last, 1);
      tick();
      chk("t6_sel0", sel, 0);
      chk("t6_rdy0", req_ready, 4'h1);
      tick();
      chk("t6_out0", out_data, mk(0, 5));
      chk("t6_src0", out_src, 0);
      tick();
      chk("t6_sel3", sel, 3);
      chk("t6_rdy3", req_ready, 4'h8);
      tick();
      drive(0, 4'h0, 4'h0, 1'b1);
      chk("t6_out3", out_data, mk(3, 2));
      chk("t6_src3", out_src, 3);
      tick();
      chk("t6_idle_busy", busy, 0);
      chk("t6_idle_ov", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
